// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit seven-segment scanner.
// Each digit slot lasts DIV clocks. The first BLANK clocks of the slot are dark
// so the previous digit does not ghost into the next one. The remaining clocks
// show the digit's segment pattern, which is captured once at the BLANK->SHOW
// edge. frame_tick pulses for one cycle at the start of slot 0 after a 3->0 wrap.
module seg_scan_mux #(
  parameter int unsigned DIV        = 50000,
  parameter int unsigned BLANK      = 500,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clean,
  input  logic       en,
  input  logic [6:0] din0,
  input  logic [6:0] din1,
  input  logic [6:0] din2,
  input  logic [6:0] din3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] scan_idx,
  output logic       frame_tick
);

  localparam int unsigned    CntW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            tick_q, tick_d;
  logic [6:0]      din_sel;
  logic [3:0]      an_onehot;

  // Select the segment pattern and digit enable for the current slot.
  always_comb begin
    din_sel   = 7'h00;
    an_onehot = 4'b0000;
    unique case (idx_q)
      2'd0: begin din_sel = din0; an_onehot = 4'b0001; end
      2'd1: begin din_sel = din1; an_onehot = 4'b0010; end
      2'd2: begin din_sel = din2; an_onehot = 4'b0100; end
      2'd3: begin din_sel = din3; an_onehot = 4'b1000; end
      default: begin din_sel = 7'h00; an_onehot = 4'b0000; end
    endcase
  end

  // Next-state: advance the slot counter, wrap slots, and latch the digit at BLANK->SHOW.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    seg_d  = seg_q;
    an_d   = an_q;
    tick_d = 1'b0;
    if (!en) begin
      // Park on the current slot; re-enabling replays it from a full blank phase.
      cnt_d = '0;
      seg_d = 7'h00;
      an_d  = 4'b0000;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        idx_d  = idx_q + 2'd1;
        seg_d  = 7'h00;
        an_d   = 4'b0000;
        tick_d = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // BLANK <= DIV-1, so this never coincides with the wrap above.
      if (cnt_q == BlankLast) begin
        seg_d = din_sel;
        an_d  = an_onehot;
      end
    end
  end

  // State register with asynchronous reset that darkens the display at once.
  always_ff @(posedge clk or posedge clean) begin
    if (clean) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      seg_q  <= 7'h00;
      an_q   <= 4'b0000;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  // Polarity is a constant XOR on registered values, so the pins stay glitch-free.
  assign an         = an_q ^ {4{ACTIVE_LOW}};
  assign seg        = seg_q ^ {7{ACTIVE_LOW}};
  assign scan_idx   = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed testbench for seg_scan_mux: one active-low instance (DIV=8, BLANK=2)
// and one active-high instance (DIV=4, BLANK=1).
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       clean_a, en_a, clean_b, en_b;
  logic [6:0] din_a [4];
  logic [6:0] din_b [4];
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic [1:0] idx_a, idx_b;
  logic       tick_a, tick_b;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIV(8), .BLANK(2), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .clean(clean_a), .en(en_a),
    .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
    .seg(seg_a), .an(an_a), .scan_idx(idx_a), .frame_tick(tick_a)
  );

  seg_scan_mux #(.DIV(4), .BLANK(1), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .clean(clean_b), .en(en_b),
    .din0(din_b[0]), .din1(din_b[1]), .din2(din_b[2]), .din3(din_b[3]),
    .seg(seg_b), .an(an_b), .scan_idx(idx_b), .frame_tick(tick_b)
  );

  // Advance one clock and sample 2 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    clean_a = 1'b1; clean_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    din_a[0] = 7'h3F; din_a[1] = 7'h06; din_a[2] = 7'h5B; din_a[3] = 7'h4F;
    din_b[0] = 7'h3F; din_b[1] = 7'h06; din_b[2] = 7'h5B; din_b[3] = 7'h4F;
    #12;
    n_cmp++;
    if ({an_a, seg_a} !== {4'b1111, 7'h7F}) begin
      n_err++; $display("FAIL reset_pins_a got %b/%h want 1111/7f", an_a, seg_a);
    end
    n_cmp++;
    if ({idx_a, tick_a} !== 3'b000) begin
      n_err++; $display("FAIL reset_state_a got idx=%0d tick=%b want 0/0", idx_a, tick_a);
    end
    n_cmp++;
    if ({an_b, seg_b, idx_b, tick_b} !== 14'd0) begin
      n_err++; $display("FAIL reset_b got an=%b seg=%h idx=%0d tick=%b want all zero",
                        an_b, seg_b, idx_b, tick_b);
    end
    #18;
    clean_a = 1'b0;
  endtask

  // Slot 0 lights after two edges for six cycles, then slot 1 after two blank cycles.
  task automatic test_first_scan();
    step();
    n_cmp++;
    if ({an_a, seg_a} !== {4'b1111, 7'h7F}) begin
      n_err++; $display("FAIL first_blank got %b/%h want 1111/7f", an_a, seg_a);
    end
    for (int k = 2; k <= 7; k++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a} !== {4'b1110, 7'h40}) begin
        n_err++; $display("FAIL first_lit k=%0d got %b/%h want 1110/40", k, an_a, seg_a);
      end
    end
    for (int k = 8; k <= 9; k++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a, idx_a} !== {4'b1111, 7'h7F, 2'd1}) begin
        n_err++; $display("FAIL gap k=%0d got %b/%h/%0d want 1111/7f/1", k, an_a, seg_a, idx_a);
      end
    end
    step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1101, 7'h79, 2'd1}) begin
      n_err++; $display("FAIL slot1_lit got %b/%h/%0d want 1101/79/1", an_a, seg_a, idx_a);
    end
  endtask

  // Two full frames: scan pattern, one-hot digits, and one tick every 32 cycles.
  task automatic test_frame_tick();
    int         c, s, ticks;
    logic [3:0] ea;
    logic [6:0] es;
    logic       et;
    ticks = 0;
    for (int k = 11; k <= 67; k++) begin
      step();
      c  = k % 8;
      s  = (k / 8) % 4;
      ea = 4'b0001 << s;
      ea = (c >= 2) ? ~ea : 4'b1111;
      es = (c >= 2) ? ~din_a[s] : 7'h7F;
      et = ((k % 32) == 0);
      if (tick_a) ticks++;
      n_cmp++;
      if ({an_a, seg_a, idx_a, tick_a} !== {ea, es, 2'(s), et}) begin
        n_err++;
        $display("FAIL frame k=%0d got %b/%h/%0d/%b want %b/%h/%0d/%b",
                 k, an_a, seg_a, idx_a, tick_a, ea, es, s, et);
      end
      n_cmp++;
      if ($countones(~an_a) > 1) begin
        n_err++; $display("FAIL onehot k=%0d got an=%b want at most one low", k, an_a);
      end
    end
    n_cmp++;
    if (ticks !== 2) begin
      n_err++; $display("FAIL tick_count got %0d want 2", ticks);
    end
  endtask

  // din0 changes mid-SHOW; the latched pattern holds until the next slot 0.
  task automatic test_din_sample();
    din_a[0] = 7'h06;
    for (int k = 68; k <= 71; k++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a} !== {4'b1110, 7'h40}) begin
        n_err++; $display("FAIL din_hold k=%0d got %b/%h want 1110/40", k, an_a, seg_a);
      end
    end
    for (int k = 72; k <= 98; k++) step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1110, 7'h79, 2'd0}) begin
      n_err++; $display("FAIL din_new got %b/%h/%0d want 1110/79/0", an_a, seg_a, idx_a);
    end
  endtask

  // en low for five edges at cnt=4 of slot 2, then the slot replays in full.
  task automatic test_en_drop();
    for (int k = 99; k <= 116; k++) step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1011, 7'h24, 2'd2}) begin
      n_err++; $display("FAIL pre_drop got %b/%h/%0d want 1011/24/2", an_a, seg_a, idx_a);
    end
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a, idx_a, tick_a} !== {4'b1111, 7'h7F, 2'd2, 1'b0}) begin
        n_err++; $display("FAIL parked i=%0d got %b/%h/%0d/%b want 1111/7f/2/0",
                          i, an_a, seg_a, idx_a, tick_a);
      end
    end
    en_a = 1'b1;
    step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1111, 7'h7F, 2'd2}) begin
      n_err++; $display("FAIL resume_blank got %b/%h/%0d want 1111/7f/2", an_a, seg_a, idx_a);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a, idx_a} !== {4'b1011, 7'h24, 2'd2}) begin
        n_err++; $display("FAIL resume_lit i=%0d got %b/%h/%0d want 1011/24/2",
                          i, an_a, seg_a, idx_a);
      end
    end
    step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1111, 7'h7F, 2'd3}) begin
      n_err++; $display("FAIL resume_next got %b/%h/%0d want 1111/7f/3", an_a, seg_a, idx_a);
    end
  endtask

  // Reset between clock edges mid-SHOW of slot 3, then the startup sequence again.
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b0111, 7'h30, 2'd3}) begin
      n_err++; $display("FAIL slot3_lit got %b/%h/%0d want 0111/30/3", an_a, seg_a, idx_a);
    end
    #3;
    clean_a = 1'b1;
    #1;
    n_cmp++;
    if ({an_a, seg_a, idx_a, tick_a} !== {4'b1111, 7'h7F, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL async_rst got %b/%h/%0d/%b want 1111/7f/0/0",
                        an_a, seg_a, idx_a, tick_a);
    end
    step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1111, 7'h7F, 2'd0}) begin
      n_err++; $display("FAIL rst_held got %b/%h/%0d want 1111/7f/0", an_a, seg_a, idx_a);
    end
    din_a[0] = 7'h3F;
    #3;
    clean_a = 1'b0;
    step();
    n_cmp++;
    if ({an_a, seg_a} !== {4'b1111, 7'h7F}) begin
      n_err++; $display("FAIL rec_blank got %b/%h want 1111/7f", an_a, seg_a);
    end
    for (int k = 2; k <= 7; k++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a} !== {4'b1110, 7'h40}) begin
        n_err++; $display("FAIL rec_lit k=%0d got %b/%h want 1110/40", k, an_a, seg_a);
      end
    end
    for (int k = 8; k <= 9; k++) begin
      step();
      n_cmp++;
      if ({an_a, seg_a, idx_a} !== {4'b1111, 7'h7F, 2'd1}) begin
        n_err++; $display("FAIL rec_gap k=%0d got %b/%h/%0d want 1111/7f/1",
                          k, an_a, seg_a, idx_a);
      end
    end
    step();
    n_cmp++;
    if ({an_a, seg_a, idx_a} !== {4'b1101, 7'h79, 2'd1}) begin
      n_err++; $display("FAIL rec_slot1 got %b/%h/%0d want 1101/79/1", an_a, seg_a, idx_a);
    end
  endtask

  // Active-high instance: three lit cycles per slot, one blank, 16-cycle frame.
  task automatic test_active_high();
    int         c, s, ticks;
    logic [3:0] ea;
    logic [6:0] es;
    logic       et;
    ticks   = 0;
    clean_b = 1'b0;
    for (int j = 1; j <= 33; j++) begin
      step();
      c  = j % 4;
      s  = (j / 4) % 4;
      ea = 4'b0001 << s;
      ea = (c >= 1) ? ea : 4'b0000;
      es = (c >= 1) ? din_b[s] : 7'h00;
      et = ((j % 16) == 0);
      if (tick_b) ticks++;
      n_cmp++;
      if ({an_b, seg_b, idx_b, tick_b} !== {ea, es, 2'(s), et}) begin
        n_err++;
        $display("FAIL active_high j=%0d got %b/%h/%0d/%b want %b/%h/%0d/%b",
                 j, an_b, seg_b, idx_b, tick_b, ea, es, s, et);
      end
    end
    n_cmp++;
    if (ticks !== 2) begin
      n_err++; $display("FAIL ah_tick_count got %0d want 2", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_frame_tick();
    test_din_sample();
    test_en_drop();
    test_async_reset();
    test_active_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
